// File: rtl/exhaustive_pattern_checker.sv
// Exhaustive stimulus sweeper with mismatch logging into a small FWFT FIFO.
// Optional feature: define STOP_ON_FIRST_ERR_EN to end the sweep at the first mismatch.
module exhaustive_pattern_checker #(
  parameter int WIDTH      = 10,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] d,
  input  logic             c1,
  input  logic             c2,
  output logic             busy,
  output logic             done,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [WIDTH-1:0] err_pattern,
  output logic             err_c1,
  output logic             err_c2,
  output logic [WIDTH:0]   err_count,
  output logic             overflow
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [AW:0]   FIFO_FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] pattern;
    logic             c1;
    logic             c2;
  } rec_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  settle_q;
  logic           launch;
  logic           mismatch;
  logic           advance;

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    fifo_cnt;
  logic           fifo_full;
  logic           pop;
  logic           wr_en;
  logic           drop;
  rec_t           mem [FIFO_DEPTH];
  rec_t           head;

  assign launch   = start && (state_q == S_IDLE || state_q == S_DONE);
  assign mismatch = (state_q == S_SAMPLE) && (c1 != c2);
  assign advance  = (state_q == S_SAMPLE) && (state_d == S_DRIVE);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
`ifdef STOP_ON_FIRST_ERR_EN
        if (c1 != c2 || d == '1) state_d = S_DONE;
        else                     state_d = S_DRIVE;
`else
        if (d == '1) state_d = S_DONE;
        else         state_d = S_DRIVE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      d         <= '0;
      settle_q  <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        d         <= '0;
        settle_q  <= '0;
        err_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (state_q == S_DRIVE) settle_q <= settle_q + CW'(1);
        if (advance) begin
          d        <= d + WIDTH'(1);
          settle_q <= '0;
        end
        if (mismatch) err_count <= err_count + (WIDTH + 1)'(1);
        if (drop)     overflow  <= 1'b1;
      end
    end
  end

  assign busy = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done = (state_q == S_DONE);

  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign fifo_full = (fifo_cnt == FIFO_FULL);
  assign err_valid = (fifo_cnt != '0);
  assign pop       = err_valid && err_ready;
  assign wr_en     = mismatch && (!fifo_full || pop);
  assign drop      = mismatch && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: the record storage is deliberately not reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{pattern: d, c1: c1, c2: c2};
  end

  assign head        = mem[rd_ptr];
  assign err_pattern = err_valid ? head.pattern : '0;
  assign err_c1      = err_valid ? head.c1 : 1'b0;
  assign err_c2      = err_valid ? head.c2 : 1'b0;

endmodule

// File: tb/tb_exhaustive_pattern_checker.sv
// Randomized bench for exhaustive_pattern_checker against a queue-based sweep model.
module tb_exhaustive_pattern_checker;

  localparam int W     = 10;
  localparam int S     = 2;
  localparam int DEPTH = 8;
  localparam int N     = 1 << W;
  localparam int PER   = S + 1;

  logic         clk = 1'b0;
  logic         rst, start, c1, c2, err_ready;
  logic [W-1:0] d, err_pattern;
  logic         busy, done, err_valid, err_c1, err_c2, overflow;
  logic [W:0]   err_count;

  always #5 clk = ~clk;

  exhaustive_pattern_checker #(.WIDTH(W), .SETTLE(S), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .d(d), .c1(c1), .c2(c2),
    .busy(busy), .done(done), .err_valid(err_valid), .err_ready(err_ready),
    .err_pattern(err_pattern), .err_c1(err_c1), .err_c2(err_c2),
    .err_count(err_count), .overflow(overflow)
  );

  // Reference gate is OR(d); the gate under test is OR(d) inverted on faulty patterns.
  bit [N-1:0] fault_vec;
  assign c2 = |d;
  assign c1 = (|d) ^ fault_vec[d];

  typedef struct {
    int pattern;
    bit c1;
    bit c2;
  } rec_t;

  rec_t q[$];
  bit   m_active, m_done, m_ovf;
  int   m_k, m_d, m_cnt;
  int   ready_pct, force_k, rst_k;
  bit   start_req;
  int   n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("d", 32'(d), m_d);
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("err_count", 32'(err_count), m_cnt);
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("err_valid", 32'(err_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("err_pattern", 32'(err_pattern), q[0].pattern);
      check("err_c1", 32'(err_c1), 32'(q[0].c1));
      check("err_c2", 32'(err_c2), 32'(q[0].c2));
    end else begin
      check("empty_head", {err_pattern, err_c1, err_c2}, 32'd0);
    end
  endtask

  // Pattern p is sampled in sweep cycle p*PER + S; the FIFO is a bounded queue.
  task automatic model_edge();
    bit   pop, full, push, stop_now;
    rec_t r;
    int   p;
    if (rst) begin
      q.delete();
      m_active = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_d = 0; m_k = 0;
      return;
    end
    pop  = (q.size() != 0) && err_ready;
    full = (q.size() == DEPTH);
    push = 0;
    stop_now = 0;
    if (m_active) begin
      p = m_k / PER;
      if ((m_k % PER) == S && fault_vec[p]) begin
        push = 1;
        m_cnt++;
        r.pattern = p;
        r.c2 = (p != 0);
        r.c1 = !r.c2;
      end
`ifdef STOP_ON_FIRST_ERR_EN
      stop_now = push;
`endif
      m_k++;
      if (stop_now || m_k == N * PER) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_d = m_k / PER;
      end
    end else if (start) begin
      m_active = 1; m_k = 0; m_done = 0; m_cnt = 0; m_ovf = 0; m_d = 0;
    end
    if (pop) q.delete(0);
    if (push) begin
      if (!full || pop) q.push_back(r);
      else              m_ovf = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
    start     = start_req || (m_active && $urandom_range(0, 99) < 3);
    start_req = 0;
    rst       = m_active && (m_k == rst_k);
    err_ready = ($urandom_range(0, 99) < ready_pct) || (m_active && m_k == force_k);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic run_sweep();
    start_req = 1;
    tick();
    for (int g = 0; g < N * PER + 8; g++) begin
      tick();
      if (!m_active) break;
    end
  endtask

  task automatic set_faults_range(input int lo, input int hi);
    fault_vec = '0;
    for (int i = lo; i <= hi; i++) fault_vec[i] = 1'b1;
  endtask

  task automatic set_faults_random(input int one_in);
    for (int i = 0; i < N; i++) fault_vec[i] = ($urandom_range(0, one_in - 1) == 0);
  endtask

  initial begin
    rst = 1; start = 0; err_ready = 0; fault_vec = '0;
    ready_pct = 0; force_k = -1; rst_k = -1; start_req = 0;
    m_active = 0; m_done = 0; m_ovf = 0; m_k = 0; m_d = 0; m_cnt = 0;
    n_checks = 0; n_errors = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(2);

    // Clean sweep: no records, done with d at the last pattern.
    ready_pct = 100;
    run_sweep();
    idle(3);

    // Single mismatch at pattern 5.
    set_faults_range(5, 5);
    ready_pct = 0;
    run_sweep();
    idle(2);
    ready_pct = 100;
    idle(4);

    // Mismatches 1..12 with no consumer: 8 kept, overflow set, then drained in order.
    set_faults_range(1, 12);
    ready_pct = 0;
    run_sweep();
    idle(2);
    ready_pct = 100;
    idle(12);

    // FIFO full when pattern 9 mismatches, consumer pops in that same cycle.
    set_faults_range(1, 9);
    ready_pct = 0;
    force_k = 9 * PER + S;
    run_sweep();
    force_k = -1;
    idle(2);

    // Random sweep aborted by reset at cycle 500 (FIFO contents from before are kept until then).
    set_faults_random(64);
    ready_pct = 50;
    rst_k = 500;
    run_sweep();
    rst_k = -1;
    idle(2);

    // Fresh random sweep after the abort.
    set_faults_random(64);
    ready_pct = 70;
    run_sweep();
    idle(2);

    // Dense random mismatches with a slow consumer, then a full drain.
    set_faults_random(8);
    ready_pct = 40;
    run_sweep();
    ready_pct = 100;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exhaustive_pattern_checker.md
Name: exhaustive_pattern_checker

Overview:
- Upstream stage of the error-log writer.
- Sweeps a WIDTH-bit stimulus bus through every value from 0 to 2^WIDTH-1 and drives it to the DUT and to the reference model.
- After a settle time, samples the two responses c1 and c2 and pushes a record for every mismatch into a small first-word-fall-through (FWFT) FIFO.
- The log writer drains that FIFO through a valid/ready handshake.
- Also keeps a total error count, an overflow flag and sweep status.

Parameters:
- WIDTH, 10: stimulus width; a sweep covers 2^WIDTH patterns.
- SETTLE, 2: cycles d is held before sampling; legal range is 1 or more.
- FIFO_DEPTH, 8: number of mismatch records buffered; must be a power of 2.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep.
- d  out  WIDTH  current stimulus pattern, registered.
- c1  in  1  DUT response (OR gate under test).
- c2  in  1  reference-model response.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next start or rst.
- err_valid  out  1  FIFO is non-empty.
- err_ready  in  1  consumer accepts the head record.
- err_pattern  out  WIDTH  pattern of the head record.
- err_c1  out  1  c1 of the head record.
- err_c2  out  1  c2 of the head record.
- err_count  out  WIDTH+1  number of mismatches in the current or last sweep.
- overflow  out  1  sticky; a mismatch was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - d=0, busy=0, done=0, err_valid=0, err_count=0, overflow=0.
  - FIFO emptied; FSM goes to IDLE.
  - err_pattern, err_c1 and err_c2 are 0 while the FIFO is empty.
- A rst asserted mid-sweep aborts the sweep immediately with the same result; no partial record is pushed.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE, with start=1:
  - Clear err_count, overflow and done; FIFO contents are kept.
  - Set d=0 and the settle counter to 0; go to DRIVE; busy=1 from the next cycle.
- start while busy is ignored.
- DRIVE:
  - Hold d; increment the settle counter.
  - When the counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE, one cycle:
  - Compare c1 with c2.
  - If they differ, err_count increments and the record {d, c1, c2} is pushed.
  - If d = 2^WIDTH-1, go to DONE: busy=0 and done=1 on the next cycle.
  - Otherwise d increments by 1, the settle counter clears, and the FSM returns to DRIVE.
- Timing:
  - Each pattern takes exactly SETTLE+1 cycles.
  - A full sweep takes 2^WIDTH*(SETTLE+1) cycles from the first DRIVE cycle.
  - The pattern counter never wraps within a sweep.
  - err_count cannot overflow, since its maximum of 2^WIDTH fits in WIDTH+1 bits.
- FIFO:
  - FWFT; head fields are valid combinationally while err_valid=1.
  - Pop when err_valid && err_ready.
  - Push on a mismatch in SAMPLE.
- FIFO boundary cases:
  - Push and pop in the same cycle while full: both are performed, occupancy is unchanged, overflow is not set.
  - Push while full without a pop: the record is dropped, overflow is set to 1, err_count still increments.
  - Push and pop in the same cycle while empty: the push is performed and err_valid rises next cycle (no bypass).
- The consumer may drain the FIFO during or after a sweep. done does not wait for the FIFO to empty.
- c1 and c2 are sampled only in SAMPLE; their values in DRIVE are ignored.

Optional Feature:
- Macro STOP_ON_FIRST_ERR_EN.
- When defined, a mismatch in SAMPLE pushes its record, increments err_count to 1, and goes directly to DONE.
  - d holds the failing pattern; done=1 and busy=0.
- When not defined, the sweep always completes all 2^WIDTH patterns as described above.

Test Plan:
- c1 tied equal to c2, start pulsed, err_ready=1 → done=1 after 1024*3 cycles, err_count=0, err_valid never 1, d=1023 at done.
- c1=OR(d), c2=OR(d) except forced to 0 when d=5 → exactly one record: err_pattern=5, err_c1=1, err_c2=0; err_count=1; overflow=0.
- Mismatch on d=1..12 with err_ready=0 → FIFO holds 8 records (patterns 1..8), err_count=12, overflow=1; draining then yields 1..8 in order.
- FIFO full with err_ready=1 during a mismatch → push and pop in the same cycle, occupancy stays 8, overflow=0.
- rst pulsed at cycle 500 of a sweep → next cycle d=0, busy=0, err_count=0, err_valid=0; a new start then completes normally.
- With STOP_ON_FIRST_ERR_EN, first mismatch at d=37 → done=1, d=37, err_count=1, one record with err_pattern=37.
